hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised stall and hazard unit for the five-stage MIPS pipeline. It replaces the fixed E/M stall comparator with a registered scoreboard of `NSLOT` in-flight writers behind D. Each writer carries its own down-counting Tnew, and only the youngest matching writer counts, so an older, slower producer can no longer cause a false stall. It also owns the HI/LO busy counter with per-operation latency, so the MDU no longer has to drive a busy signal to this block.

## Interface
Parameters:
- `NSLOT`, 2: tracked stages after D (E, M, …); must be at least 1.
- `RA_W`, 5: register address width.
- `T_W`, 3: Tuse/Tnew width.
- `MULT_LAT`, 5: HI/LO busy cycles for mult/multu, counted from issue into E.
- `DIV_LAT`, 10: the same for div/divu.
- `CNT_W`, 4: busy counter width; must satisfy `2**CNT_W > max(MULT_LAT, DIV_LAT)`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `d_valid`, in, 1: D holds a real instruction.
- `d_a1`, `d_a2`, in, RA_W: rs and rt read addresses.
- `d_tuse_rs`, `d_tuse_rt`, in, T_W: Tuse per operand; an operand that is not read is encoded as all-ones.
- `d_we`, in, 1: D instruction writes the GPR file.
- `d_a3`, in, RA_W: destination address.
- `d_tnew`, in, T_W: Tnew measured at E (load 2, calc 1, link 0).
- `d_hilo`, in, 1: D reads or writes HI/LO (mfhi, mflo, mthi, mtlo, mult*, div*).
- `d_md_start`, in, 1: D is a mult* or div*.
- `d_md_div`, in, 1: that operation is a divide.
- `flush`, in, 1: squash all in-flight slots.
- `stall`, out, 1: freeze F/D and insert a bubble into E.
- `stall_mdu`, out, 1: the HI/LO component of `stall`.
- `mdu_busy`, out, 1: busy counter is non-zero.
- `rs_hit`, `rt_hit`, out, NSLOT: one-hot youngest matching slot, used as the forwarding select.

## Operation
- Slot state, per slot: `v`, `we`, `a3`, `tnew`. Slot 0 is E, and slot i is i stages after E.
- Match rule for slot i on an operand: `v && we && a3 != 0 && a3 == addr`.
- Hit vector: `rs_hit` / `rt_hit` is the lowest-index matching slot, one-hot, or zero when nothing matches.
- Operand stall: asserted if the youngest matching slot has `tuse < tnew`. Older matches are ignored.
- `stall_mdu`: equals `d_valid && d_hilo && mdu_busy`.
- `stall`: equals `d_valid && (stall_rs | stall_rt | stall_mdu)`.
- Update at each edge when `flush` is asserted:
  - All slot `v` bits are cleared.
  - The busy counter is cleared.
- Update at each edge otherwise:
  - `slot[i] <= slot[i-1]` with `tnew` decremented, saturating at 0.
  - `slot[0]` takes the D fields with `v = d_valid`, `tnew = d_tnew`, or becomes a bubble (`v = 0`) if `stall`.
- The slot shift never freezes; only D is held.
- Busy counter states:
  - IDLE: count 0.
  - BUSY: count > 0.
- Busy counter transitions:
  - Loads `MULT_LAT` or `DIV_LAT` when `d_valid && d_md_start && !stall && !flush`.
  - Otherwise decrements while non-zero.
  - An MD op behind a busy MDU is held by `stall_mdu`, so a load never overlaps a count.

## Timing
- Reset values:
  - All slot `v` bits are 0.
  - The busy counter is 0.
  - `mdu_busy` = 0, `stall` = 0, `stall_mdu` = 0.
  - `rs_hit` = 0, `rt_hit` = 0.
- Combinational paths: `stall` and the hit vectors are purely combinational from registered slot state and the D inputs, with zero latency.
- Load-use case: a load in E followed by an ALU consumer in D stalls for exactly 1 cycle (Tnew 2 > Tuse 1).
- Branch case: a load in E followed by a branch consumer in D stalls for 2 cycles.
- Busy duration: after an accepted mult, `mdu_busy` is high for exactly `MULT_LAT` cycles.
- Simultaneous flush and D issue: flush wins, the D instruction is not captured, and the busy counter is not loaded.
- Reset during a divide: the counter goes to 0 asynchronously.

## Structure
- Shared package:
  - `TNEW_LOAD` = 2, `TNEW_CALC` = 1, `TNEW_LINK` = 0.
  - `TUSE_NONE` = all-ones.
  - Default `MULT_LAT` / `DIV_LAT`.
  - Slot struct `{v, we, a3, tnew}`.
- Sub-module `mdu_busy_counter`, with ports `clk`, `reset`, `load`, `is_div`, `clear`, `busy`.
- Priority pick: a generate loop in the top module.

## Test plan
- Load-use: `lw $3` in D, then `addu $4,$3,$3` with Tuse 1. Expect `stall` = 1 for exactly 1 cycle, one bubble in E, then `rs_hit` = 2'b10 (M).
- Youngest wins:
  - Slot 0 holds `jal`-style write of $31 with Tnew 0.
  - Slot 1 holds `lw $31` with Tnew 1.
  - D holds `jr $31` with Tuse 0.
  - Expect `stall` = 0 and `rs_hit` = 2'b01.
- $0 writer: `lw $0` in E, `addu` reading $0 in D. Expect `stall` = 0 and `rs_hit` = 0.
- MDU latency:
  - Accept `mult` with `MULT_LAT` = 5, then `mflo`.
  - Expect `stall_mdu` = 1 for 5 cycles, then `mflo` issues.
  - With `DIV_LAT` = 10, a following `div` stalls for 10 cycles.
- Flush: assert `flush` 3 cycles into a `div`. Next cycle expect `mdu_busy` = 0, all slots empty, and `stall` = 0 for any D instruction.
- Parameter sweep: `NSLOT` = 3 with `lw` Tnew 3. Tnew decrements 3→2→1 across slots, and a Tuse 0 consumer stalls 3 cycles.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: Tnew/Tuse encodings,
// default latencies, the in-flight slot record and the MDU busy-counter states.
package hazard_scoreboard_pkg;

    localparam int unsigned NSLOT_DEF    = 2;
    localparam int unsigned RA_W_DEF     = 5;
    localparam int unsigned T_W_DEF      = 3;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam int unsigned CNT_W_DEF    = 4;

    localparam logic [T_W_DEF-1:0] TNEW_LOAD = T_W_DEF'(2);
    localparam logic [T_W_DEF-1:0] TNEW_CALC = T_W_DEF'(1);
    localparam logic [T_W_DEF-1:0] TNEW_LINK = T_W_DEF'(0);
    localparam logic [T_W_DEF-1:0] TUSE_NONE = '1;

    // One in-flight writer; field widths follow the package address/Tnew widths
    typedef struct packed {
        logic                v;
        logic                we;
        logic [RA_W_DEF-1:0] a3;
        logic [T_W_DEF-1:0]  tnew;
    } slot_t;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic [T_W_DEF-1:0] tnew_dec(input logic [T_W_DEF-1:0] t);
        return (t == '0) ? t : t - T_W_DEF'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bus: decoded D fields and flush in, stall and
// forwarding-select results out.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSLOT = NSLOT_DEF,
    parameter int unsigned RA_W  = RA_W_DEF,
    parameter int unsigned T_W   = T_W_DEF
);
    logic             d_valid;
    logic [RA_W-1:0]  d_a1;
    logic [RA_W-1:0]  d_a2;
    logic [T_W-1:0]   d_tuse_rs;
    logic [T_W-1:0]   d_tuse_rt;
    logic             d_we;
    logic [RA_W-1:0]  d_a3;
    logic [T_W-1:0]   d_tnew;
    logic             d_hilo;
    logic             d_md_start;
    logic             d_md_div;
    logic             flush;
    logic             stall;
    logic             stall_mdu;
    logic             mdu_busy;
    logic [NSLOT-1:0] rs_hit;
    logic [NSLOT-1:0] rt_hit;

    modport master (
        output d_valid, d_a1, d_a2, d_tuse_rs, d_tuse_rt, d_we, d_a3, d_tnew,
               d_hilo, d_md_start, d_md_div, flush,
        input  stall, stall_mdu, mdu_busy, rs_hit, rt_hit
    );

    modport slave (
        input  d_valid, d_a1, d_a2, d_tuse_rs, d_tuse_rt, d_we, d_a3, d_tnew,
               d_hilo, d_md_start, d_md_div, flush,
        output stall, stall_mdu, mdu_busy, rs_hit, rt_hit
    );
endinterface

// File: rtl/hazard_scoreboard_mdu_busy_counter.sv
// HI/LO busy counter: loads the op latency on issue into E and counts down to
// idle; clear (flush) has priority over load.
module mdu_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    input  logic clear,
    output logic busy
);
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = MDU_IDLE;
            cnt_d   = '0;
        end else if (load) begin
            state_d = MDU_BUSY;
            cnt_d   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else begin
            case (state_q)
                MDU_IDLE: ;
                MDU_BUSY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = MDU_IDLE;
                end
                default: state_d = MDU_IDLE;
            endcase
        end
    end

    assign busy = (state_q == MDU_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/hazard unit: shift register of in-flight writers behind D with
// per-writer Tnew, youngest-match forwarding select and HI/LO busy tracking.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NSLOT    = NSLOT_DEF,
    parameter int unsigned RA_W     = RA_W_DEF,
    parameter int unsigned T_W      = T_W_DEF,
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input logic               clk,
    input logic               reset,
    hazard_scoreboard_if.slave hz
);
    slot_t            slot_q [NSLOT];
    slot_t            slot_d [NSLOT];
    logic [NSLOT-1:0] rs_match, rt_match;
    logic [NSLOT-1:0] rs_hit, rt_hit;
    logic [NSLOT-1:0] rs_late, rt_late;
    logic             stall_rs, stall_rt, stall_mdu, stall;
    logic             md_load, mdu_busy;

    // Priority pick: a slot hits only if no younger (lower-index) slot matches
    for (genvar i = 0; i < NSLOT; i++) begin : g_pick
        assign rs_match[i] = slot_q[i].v && slot_q[i].we && (slot_q[i].a3 != '0)
                             && (RA_W'(slot_q[i].a3) == hz.d_a1);
        assign rt_match[i] = slot_q[i].v && slot_q[i].we && (slot_q[i].a3 != '0)
                             && (RA_W'(slot_q[i].a3) == hz.d_a2);
        assign rs_late[i]  = hz.d_tuse_rs < T_W'(slot_q[i].tnew);
        assign rt_late[i]  = hz.d_tuse_rt < T_W'(slot_q[i].tnew);
        if (i == 0) begin : g_youngest
            assign rs_hit[i] = rs_match[i];
            assign rt_hit[i] = rt_match[i];
        end else begin : g_older
            assign rs_hit[i] = rs_match[i] && !(|rs_match[i-1:0]);
            assign rt_hit[i] = rt_match[i] && !(|rt_match[i-1:0]);
        end
    end

    assign stall_rs  = |(rs_hit & rs_late);
    assign stall_rt  = |(rt_hit & rt_late);
    assign stall_mdu = hz.d_valid && hz.d_hilo && mdu_busy;
    assign stall     = hz.d_valid && (stall_rs || stall_rt || stall_mdu);
    assign md_load   = hz.d_valid && hz.d_md_start && !stall && !hz.flush;

    // Slots always advance; a stalled or flushed D enters E as a bubble
    always_comb begin
        for (int i = 0; i < NSLOT; i++) slot_d[i] = '0;
        if (!hz.flush) begin
            slot_d[0].v    = hz.d_valid && !stall;
            slot_d[0].we   = hz.d_we;
            slot_d[0].a3   = RA_W_DEF'(hz.d_a3);
            slot_d[0].tnew = T_W_DEF'(hz.d_tnew);
            for (int i = 1; i < NSLOT; i++) begin
                slot_d[i]      = slot_q[i-1];
                slot_d[i].tnew = tnew_dec(slot_q[i-1].tnew);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    mdu_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_mdu_busy (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .is_div (hz.d_md_div),
        .clear  (hz.flush),
        .busy   (mdu_busy)
    );

    assign hz.stall     = stall;
    assign hz.stall_mdu = stall_mdu;
    assign hz.mdu_busy  = mdu_busy;
    assign hz.rs_hit    = rs_hit;
    assign hz.rt_hit    = rt_hit;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: per-cycle vector table through an expectation
// queue, plus hand-written flush, latency, reset and NSLOT=3 sequences.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [2:0] tuse_rs;
        logic [2:0] tuse_rt;
        logic       we;
        logic [4:0] a3;
        logic [2:0] tnew;
        logic       hilo;
        logic       md_start;
        logic       md_div;
        logic       flush;
    } din_t;

    typedef struct packed {
        logic       stall;
        logic       stall_mdu;
        logic       busy;
        logic [1:0] rs_hit;
        logic [1:0] rt_hit;
    } dexp_t;

    typedef struct packed {
        din_t  d;
        dexp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NSLOT(2), .RA_W(5), .T_W(3)) bus2 ();
    hazard_scoreboard_if #(.NSLOT(3), .RA_W(5), .T_W(3)) bus3 ();

    hazard_scoreboard #(.NSLOT(2)) dut2 (.clk(clk), .reset(reset), .hz(bus2));
    hazard_scoreboard #(.NSLOT(3)) dut3 (.clk(clk), .reset(reset), .hz(bus3));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    function automatic din_t i_nop();
        din_t d = '0;
        return d;
    endfunction

    function automatic din_t i_lw(input logic [4:0] rt, input logic [2:0] tn);
        din_t d = '0;
        d.valid = 1'b1; d.a1 = 5'd29; d.tuse_rs = 3'd1;
        d.a2 = rt; d.tuse_rt = TUSE_NONE;
        d.we = 1'b1; d.a3 = rt; d.tnew = tn;
        return d;
    endfunction

    function automatic din_t i_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        din_t d = '0;
        d.valid = 1'b1; d.a1 = rs; d.a2 = rt; d.tuse_rs = 3'd1; d.tuse_rt = 3'd1;
        d.we = 1'b1; d.a3 = rd; d.tnew = TNEW_CALC;
        return d;
    endfunction

    function automatic din_t i_jal();
        din_t d = '0;
        d.valid = 1'b1; d.tuse_rs = TUSE_NONE; d.tuse_rt = TUSE_NONE;
        d.we = 1'b1; d.a3 = 5'd31; d.tnew = TNEW_LINK;
        return d;
    endfunction

    function automatic din_t i_br(input logic [4:0] rs, input logic [2:0] tuse);
        din_t d = '0;
        d.valid = 1'b1; d.a1 = rs; d.tuse_rs = tuse; d.tuse_rt = TUSE_NONE;
        return d;
    endfunction

    function automatic din_t i_md(input logic is_div);
        din_t d = '0;
        d.valid = 1'b1; d.a1 = 5'd8; d.a2 = 5'd9; d.tuse_rs = 3'd1; d.tuse_rt = 3'd1;
        d.hilo = 1'b1; d.md_start = 1'b1; d.md_div = is_div;
        return d;
    endfunction

    function automatic din_t i_mflo(input logic [4:0] rd);
        din_t d = '0;
        d.valid = 1'b1; d.tuse_rs = TUSE_NONE; d.tuse_rt = TUSE_NONE;
        d.hilo = 1'b1; d.we = 1'b1; d.a3 = rd; d.tnew = TNEW_CALC;
        return d;
    endfunction

    function automatic dexp_t ex(input logic s, input logic sm, input logic b,
                                 input logic [1:0] rs, input logic [1:0] rt);
        dexp_t x;
        x.stall = s; x.stall_mdu = sm; x.busy = b; x.rs_hit = rs; x.rt_hit = rt;
        return x;
    endfunction

    task automatic drive2(input din_t d);
        bus2.d_valid = d.valid; bus2.d_a1 = d.a1; bus2.d_a2 = d.a2;
        bus2.d_tuse_rs = d.tuse_rs; bus2.d_tuse_rt = d.tuse_rt;
        bus2.d_we = d.we; bus2.d_a3 = d.a3; bus2.d_tnew = d.tnew;
        bus2.d_hilo = d.hilo; bus2.d_md_start = d.md_start; bus2.d_md_div = d.md_div;
        bus2.flush = d.flush;
    endtask

    task automatic drive3(input din_t d);
        bus3.d_valid = d.valid; bus3.d_a1 = d.a1; bus3.d_a2 = d.a2;
        bus3.d_tuse_rs = d.tuse_rs; bus3.d_tuse_rt = d.tuse_rt;
        bus3.d_we = d.we; bus3.d_a3 = d.a3; bus3.d_tnew = d.tnew;
        bus3.d_hilo = d.hilo; bus3.d_md_start = d.md_start; bus3.d_md_div = d.md_div;
        bus3.flush = d.flush;
    endtask

    vec_t  tbl[$];
    dexp_t exp_q[$];

    task automatic add(input din_t d, input dexp_t x, input int n);
        vec_t v;
        v.d = d;
        v.e = x;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        din_t       tmp;
        dexp_t      x;
        int         n;
        logic [2:0] hexp [4];

        // Each row is one cycle of D contents; stalled instructions are repeated
        add(i_lw(5'd3, TNEW_LOAD),       ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_alu(5'd4, 5'd3, 5'd3),     ex(1, 0, 0, 2'b01, 2'b01), 1);
        add(i_alu(5'd4, 5'd3, 5'd3),     ex(0, 0, 0, 2'b10, 2'b10), 1);
        add(i_nop(),                     ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_lw(5'd31, TNEW_LOAD),      ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_jal(),                     ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_br(5'd31, 3'd0),           ex(0, 0, 0, 2'b01, 2'b00), 1);
        add(i_nop(),                     ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_lw(5'd0, TNEW_LOAD),       ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_alu(5'd5, 5'd0, 5'd0),     ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_nop(),                     ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_md(1'b0),                  ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_mflo(5'd10),               ex(1, 1, 1, 2'b00, 2'b00), 5);
        add(i_mflo(5'd10),               ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_md(1'b1),                  ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_md(1'b1),                  ex(1, 1, 1, 2'b00, 2'b00), 10);
        add(i_md(1'b1),                  ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_lw(5'd7, TNEW_LOAD),       ex(0, 0, 1, 2'b00, 2'b00), 1);
        add(i_lw(5'd6, TNEW_LOAD),       ex(0, 0, 1, 2'b00, 2'b00), 1);
        tmp = i_alu(5'd9, 5'd7, 5'd6);
        tmp.flush = 1'b1;
        add(tmp,                         ex(1, 0, 1, 2'b10, 2'b01), 1);
        add(i_alu(5'd9, 5'd7, 5'd6),     ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_mflo(5'd10),               ex(0, 0, 0, 2'b00, 2'b00), 1);
        add(i_nop(),                     ex(0, 0, 0, 2'b00, 2'b00), 1);

        // Reset state, with D presenting instructions that would otherwise stall
        reset = 1'b1;
        drive2(i_mflo(5'd10));
        drive3(i_br(5'd3, 3'd0));
        repeat (2) @(posedge clk);
        #1;
        check("rst stall",     32'(bus2.stall),     32'(0));
        check("rst stall_mdu", 32'(bus2.stall_mdu), 32'(0));
        check("rst mdu_busy",  32'(bus2.mdu_busy),  32'(0));
        check("rst rs_hit",    32'(bus2.rs_hit),    32'(0));
        check("rst rt_hit",    32'(bus2.rt_hit),    32'(0));
        check("rst n3 stall",  32'(bus3.stall),     32'(0));
        drive2(i_nop());
        drive3(i_nop());
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive2(tbl[i].d);
            exp_q.push_back(tbl[i].e);
            #1;
            x = exp_q.pop_front();
            check($sformatf("r%0d stall", i),     32'(bus2.stall),     32'(x.stall));
            check($sformatf("r%0d stall_mdu", i), 32'(bus2.stall_mdu), 32'(x.stall_mdu));
            check($sformatf("r%0d mdu_busy", i),  32'(bus2.mdu_busy),  32'(x.busy));
            check($sformatf("r%0d rs_hit", i),    32'(bus2.rs_hit),    32'(x.rs_hit));
            check($sformatf("r%0d rt_hit", i),    32'(bus2.rt_hit),    32'(x.rt_hit));
        end

        // Flush together with an MD issue: the counter must not load
        @(posedge clk); #1;
        tmp = i_md(1'b0);
        tmp.flush = 1'b1;
        drive2(tmp); #1;
        check("flush+mult stall", 32'(bus2.stall), 32'(0));
        @(posedge clk); #1;
        drive2(i_nop()); #1;
        check("flush+mult busy", 32'(bus2.mdu_busy), 32'(0));

        // Flush together with a load: the load must not be captured
        @(posedge clk); #1;
        tmp = i_lw(5'd12, TNEW_LOAD);
        tmp.flush = 1'b1;
        drive2(tmp); #1;
        @(posedge clk); #1;
        drive2(i_alu(5'd13, 5'd12, 5'd12)); #1;
        check("flush+lw rs_hit", 32'(bus2.rs_hit), 32'(0));
        check("flush+lw stall",  32'(bus2.stall),  32'(0));

        // Busy duration after an accepted mult and an accepted div
        for (int op = 0; op < 2; op++) begin
            @(posedge clk); #1;
            drive2(i_md(op[0])); #1;
            check($sformatf("md%0d accept stall", op), 32'(bus2.stall), 32'(0));
            @(posedge clk); #1;
            drive2(i_nop()); #1;
            n = 0;
            for (int k = 0; k < 40 && bus2.mdu_busy; k++) begin
                n++;
                @(posedge clk); #2;
            end
            check($sformatf("md%0d busy cycles", op), 32'(n), (op == 0) ? 32'(5) : 32'(10));
        end

        // Reset mid-divide clears the counter without waiting for a clock edge
        @(posedge clk); #1;
        drive2(i_md(1'b1)); #1;
        @(posedge clk); #1;
        drive2(i_mflo(5'd10)); #1;
        check("div busy before reset", 32'(bus2.stall_mdu), 32'(1));
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async rst mdu_busy",  32'(bus2.mdu_busy),  32'(0));
        check("async rst stall_mdu", 32'(bus2.stall_mdu), 32'(0));
        check("async rst stall",     32'(bus2.stall),     32'(0));
        @(negedge clk);
        drive2(i_nop());
        reset = 1'b0;

        // NSLOT=3: a Tnew-3 load ages 3->2->1 across the slots
        hexp = '{3'b001, 3'b010, 3'b100, 3'b000};
        @(posedge clk); #1;
        drive3(i_lw(5'd3, 3'd3)); #1;
        check("n3 lw stall", 32'(bus3.stall), 32'(0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive3(i_br(5'd3, 3'd0)); #1;
            check($sformatf("n3 tuse0 c%0d stall", k),  32'(bus3.stall),  (k < 3) ? 32'(1) : 32'(0));
            check($sformatf("n3 tuse0 c%0d rs_hit", k), 32'(bus3.rs_hit), 32'(hexp[k]));
        end
        @(posedge clk); #1;
        drive3(i_lw(5'd3, 3'd3)); #1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive3(i_br(5'd3, 3'd2)); #1;
            check($sformatf("n3 tuse2 c%0d stall", k),  32'(bus3.stall),  (k == 0) ? 32'(1) : 32'(0));
            check($sformatf("n3 tuse2 c%0d rs_hit", k), 32'(bus3.rs_hit), 32'(hexp[k]));
        end
        @(posedge clk); #1;
        drive3(i_nop());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
